pe_operand_loader: RTL and testbench
====================================

Name: pe_operand_loader

Overview:
- Upstream feeder for pe_controller.
- Fetches weight and activation tiles from the on-chip buffer as 16-bit words, each packing NUM_COMPUTE_LANES signed 4-bit operands, and unpacks them into the flattened row-major weights_in and datas_arr arrays.
- Pulses load_en once the weights are complete, then holds compute high for a fixed window while the pe_controller skews and consumes the data tile.
- Raises done when the window closes.

Parameters:
- ARRAY_SIZE, 8, systolic array dimension N; a tile is N*N elements.
- COMPUTE_DATA_WIDTH, 4, signed operand width.
- BUFFER_WORD_SIZE, 16, buffer read-data width.
- NUM_COMPUTE_LANES, BUFFER_WORD_SIZE/COMPUTE_DATA_WIDTH (4), operands per buffer word.
- ADDR_WIDTH, 10, buffer address width.
- COMPUTE_CYCLES, 3*ARRAY_SIZE-2 (22), number of cycles compute is held high.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run one tile; ignored while busy.
- w_base_addr  in  ADDR_WIDTH  weight tile base word address; sampled on accepted start.
- d_base_addr  in  ADDR_WIDTH  data tile base word address; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of the compute window.
- buf_rd_en  out  1  one-cycle read request.
- buf_rd_addr  out  ADDR_WIDTH  read address; valid while buf_rd_en is high.
- buf_rd_data  in  BUFFER_WORD_SIZE  returned read word.
- buf_rd_valid  in  1  buf_rd_data is valid this cycle.
- load_en  out  1  one-cycle weight-load pulse to pe_controller.
- compute  out  1  compute enable to pe_controller.
- weights_in  out  N*N x COMPUTE_DATA_WIDTH signed  unpacked weight tile.
- datas_arr  out  N*N x COMPUTE_DATA_WIDTH signed  unpacked data tile.

Behaviour:

Reset:
- While rst is low: state=IDLE, all counters 0.
- Every output is 0, including all elements of weights_in and datas_arr.
- Reset asserted mid-operation aborts immediately; no done pulse is produced.
- Any buf_rd_valid arriving after reset deasserts is ignored.

Tile size:
- WORDS = N*N/NUM_COMPUTE_LANES (16 by default).

Packing:
- Word k, lane j (bits [4j+3:4j]) maps to array element k*NUM_COMPUTE_LANES+j.
- Lane 0 occupies the LSBs.
- Operands are copied bit-exact; no sign extension or arithmetic is applied.

Read handshake:
- At most one read is outstanding.
- buf_rd_en is high for exactly one cycle with buf_rd_addr = base+k.
- The FSM then waits any number of cycles (at least 1) for buf_rd_valid.
- The word is written on the valid cycle; the next request may issue on the following cycle.
- buf_rd_valid with no read outstanding is ignored.

FSM:
- IDLE: when start is accepted, latch both base addresses, k=0, go to RD_W.
- RD_W: fetch WORDS weight words into weights_in. After the last word lands, go to LOAD.
- LOAD: load_en=1 for one cycle; weights_in is already complete. Go to RD_D.
- RD_D: fetch WORDS data words into datas_arr. After the last word lands, go to COMP.
- COMP: compute=1 for exactly COMPUTE_CYCLES consecutive cycles, tracked by a cycle counter. Go to DONE.
- DONE: done=1 for one cycle, busy drops in the same cycle. Go to IDLE.

Output stability:
- weights_in is stable from LOAD until the next accepted start.
- datas_arr is stable throughout COMP and after it.
- Both arrays retain their values after done.

Sequencing:
- start asserted in the same cycle as done is ignored.
- A new tile requires start in IDLE.
- Address generation is base+k modulo 2^ADDR_WIDTH, wrapping silently.
- Minimum latency from start to done is 2*WORDS*2 + 1 + COMPUTE_CYCLES + 1 cycles. This corresponds to 1-cycle read latency; the FSM takes one cycle per request and one per valid.

Optional Feature:
- Macro: PE_LOADER_WEIGHT_REUSE_EN.
- Defined:
  - Adds input port reuse_weights (1 bit), sampled on an accepted start.
  - If reuse_weights=1, the FSM goes IDLE→RD_D directly, skipping RD_W and LOAD. weights_in is unchanged and load_en is not pulsed.
  - If reuse_weights=0, the full sequence runs.
- Undefined:
  - The reuse_weights port does not exist.
  - Every tile runs RD_W and LOAD.

Test Plan:
- Reset, then start with w_base=0x000 and d_base=0x040; the buffer returns word k as {4'(k+3),4'(k+2),4'(k+1),4'(k)} with 1-cycle latency.
  - Required: weights_in[4k+j] == (k+j)%16 and datas_arr likewise.
  - Required: 16 reads at 0x000–0x00F, then 16 at 0x040–0x04F.
  - Required: load_en pulses once, between the two read bursts.
  - Required: compute is high for exactly 22 cycles, then done pulses once.
- Random read latency of 1–5 cycles, plus spurious buf_rd_valid pulses while no read is outstanding.
  - Required: arrays identical to the fixed-latency run.
  - Required: never more than one outstanding request; spurious valids ignored.
- Assert start repeatedly while busy, including in the done cycle.
  - Required: exactly one tile executed and exactly one done pulse.
- Drive rst low during RD_D (after 5 data words) and during COMP (cycle 10).
  - Required: all outputs are 0 on the same edge; no done pulse; a fresh start completes normally.
- w_base=0x3FE with ADDR_WIDTH=10.
  - Required: read addresses 0x3FE, 0x3FF, 0x000…0x00D in order.
- With PE_LOADER_WEIGHT_REUSE_EN defined, run tile 1 with reuse=0, then tile 2 with reuse=1 and new data.
  - Required: tile 2 issues only 16 reads, has no load_en pulse, and weights_in is unchanged.

Source files
------------

// File: rtl/pe_operand_loader.sv
// Operand loader for pe_controller: fetches packed weight/data tiles from the buffer,
// unpacks them, pulses load_en and holds compute for a fixed window. Optional: PE_LOADER_WEIGHT_REUSE_EN.
module pe_operand_loader #(
  parameter int ARRAY_SIZE         = 8,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int BUFFER_WORD_SIZE   = 16,
  parameter int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
  parameter int ADDR_WIDTH         = 10,
  parameter int COMPUTE_CYCLES     = 3 * ARRAY_SIZE - 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                w_base_addr,
  input  logic [ADDR_WIDTH-1:0]                d_base_addr,
`ifdef PE_LOADER_WEIGHT_REUSE_EN
  input  logic                                 reuse_weights,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 buf_rd_en,
  output logic [ADDR_WIDTH-1:0]                buf_rd_addr,
  input  logic [BUFFER_WORD_SIZE-1:0]          buf_rd_data,
  input  logic                                 buf_rd_valid,
  output logic                                 load_en,
  output logic                                 compute,
  output logic signed [COMPUTE_DATA_WIDTH-1:0] weights_in [ARRAY_SIZE*ARRAY_SIZE],
  output logic signed [COMPUTE_DATA_WIDTH-1:0] datas_arr  [ARRAY_SIZE*ARRAY_SIZE],
  output logic [2:0]                           state_dbg
);

  localparam int ELEMS = ARRAY_SIZE * ARRAY_SIZE;
  localparam int WORDS = ELEMS / NUM_COMPUTE_LANES;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(COMPUTE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RD_W = 3'd1, S_LOAD = 3'd2, S_RD_D = 3'd3, S_COMP = 3'd4, S_DONE = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [KW-1:0]         k;
  logic [CW-1:0]         cyc;
  logic                  pend;
  logic [ADDR_WIDTH-1:0] w_base, d_base;
  logic                  reading, word_ok, last_word, reuse_sel;

`ifdef PE_LOADER_WEIGHT_REUSE_EN
  assign reuse_sel = reuse_weights;
`else
  assign reuse_sel = 1'b0;
`endif

  // Read handshake: buf_rd_en is a one-cycle request (pend is clear); pend then stays set
  // until a buf_rd_valid lands, so at most one read is outstanding and a valid seen
  // while pend is clear (including the request cycle itself) is ignored.
  assign reading   = (state == S_RD_W) || (state == S_RD_D);
  assign word_ok   = reading && pend && buf_rd_valid;
  assign last_word = (k == KW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = reuse_sel ? S_RD_D : S_RD_W;
      S_RD_W: if (word_ok && last_word) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_RD_D;
      S_RD_D: if (word_ok && last_word) state_nxt = S_COMP;
      S_COMP: if (cyc == CW'(COMPUTE_CYCLES - 1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE) && (state != S_DONE);
    done        = (state == S_DONE);
    load_en     = (state == S_LOAD);
    compute     = (state == S_COMP);
    buf_rd_en   = reading && !pend;
    buf_rd_addr = '0;
    if (buf_rd_en)
      buf_rd_addr = ((state == S_RD_W) ? w_base : d_base) + ADDR_WIDTH'(k);
    state_dbg   = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      cyc    <= '0;
      pend   <= 1'b0;
      w_base <= '0;
      d_base <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        w_base <= w_base_addr;
        d_base <= d_base_addr;
        k      <= '0;
        pend   <= 1'b0;
      end
      if (reading) begin
        if (!pend) pend <= 1'b1;
        else if (buf_rd_valid) begin
          pend <= 1'b0;
          k    <= last_word ? '0 : k + KW'(1);
        end
      end
      cyc <= (state == S_COMP) ? cyc + CW'(1) : '0;
    end
  end

  // Lane j of word k lands bit-exact in element k*NUM_COMPUTE_LANES+j.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < ELEMS; e++) begin
        weights_in[e] <= '0;
        datas_arr[e]  <= '0;
      end
    end else if (word_ok) begin
      for (int e = 0; e < ELEMS; e++) begin
        if (k == KW'(e / NUM_COMPUTE_LANES)) begin
          if (state == S_RD_W)
            weights_in[e] <= buf_rd_data[(e % NUM_COMPUTE_LANES)*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH];
          else
            datas_arr[e]  <= buf_rd_data[(e % NUM_COMPUTE_LANES)*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_operand_loader.sv
// Directed bench for pe_operand_loader: buffer responder, address scoreboard, event monitor.
module tb_pe_operand_loader;
  localparam int W = 4, BW = 16, L = 4, AW = 10, ELEMS = 64, WORDS = 16, CC = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] w_base_addr = '0, d_base_addr = '0;
  logic reuse_weights = 1'b0;
  logic busy, done, buf_rd_en, load_en, compute;
  logic [AW-1:0] buf_rd_addr;
  logic [BW-1:0] buf_rd_data;
  logic buf_rd_valid;
  logic signed [W-1:0] weights_in [ELEMS];
  logic signed [W-1:0] datas_arr  [ELEMS];
  logic [2:0] state_dbg;

  pe_operand_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .w_base_addr(w_base_addr), .d_base_addr(d_base_addr),
`ifdef PE_LOADER_WEIGHT_REUSE_EN
    .reuse_weights(reuse_weights),
`endif
    .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .buf_rd_valid(buf_rd_valid), .load_en(load_en),
    .compute(compute), .weights_in(weights_in), .datas_arr(datas_arr), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_asserts = 0, n_fail = 0;
  logic [AW-1:0] exp_q[$];
  logic [W-1:0] exp_w [ELEMS];
  logic [W-1:0] exp_d [ELEMS];
  logic [3:0] salt = 4'h0;
  bit spur_on = 1'b0;
  int overlap_cnt = 0, resp_cnt = 0, rd_cnt = 0, rd_at_load = -1;
  int n_load = 0, n_done = 0, cur_run = 0, run_at_done = -1;
  logic [AW-1:0] resp_addr;
  int resp_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_val(input logic [AW-1:0] a, input int j);
    logic [AW-1:0] t;
    t = a + AW'(j);
    return t[3:0] ^ salt;
  endfunction

  function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
    logic [BW-1:0] w;
    for (int j = 0; j < L; j++) w[j*W +: W] = lane_val(a, j);
    return w;
  endfunction

  // buffer responder: pops the expected address of every request
  initial begin
    buf_rd_valid = 1'b0;
    buf_rd_data  = '0;
    forever begin
      @(negedge clk);
      buf_rd_valid = 1'b0;
      if (buf_rd_en) begin
        resp_addr = buf_rd_addr;
        check("rd_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rd_addr", buf_rd_addr, exp_q.pop_front());
        if (spur_on && $urandom_range(0, 1) == 1) begin
          buf_rd_valid = 1'b1;
          buf_rd_data  = 16'hBAD0 ^ 16'($urandom_range(0, 15));
        end
        resp_lat = spur_on ? $urandom_range(1, 5) : 1;
        for (int i = 0; i < resp_lat; i++) begin
          @(negedge clk);
          buf_rd_valid = 1'b0;
          buf_rd_data  = '0;
          if (buf_rd_en) overlap_cnt++;
        end
        buf_rd_valid = 1'b1;
        buf_rd_data  = mem_word(resp_addr);
        resp_cnt++;
      end else if (spur_on && $urandom_range(0, 7) == 0) begin
        buf_rd_valid = 1'b1;
        buf_rd_data  = 16'hFFFF;
      end
    end
  end

  // event monitor
  initial begin
    forever begin
      @(negedge clk);
      if (buf_rd_en) rd_cnt++;
      if (load_en) begin n_load++; rd_at_load = rd_cnt; end
      if (compute) cur_run++;
      else begin
        if (done) begin n_done++; run_at_done = cur_run; end
        cur_run = 0;
      end
    end
  end

  task automatic prep_and_start(input logic [AW-1:0] wb, input logic [AW-1:0] db, input bit reuse);
    logic [AW-1:0] a;
    for (int k = 0; k < WORDS; k++) begin
      if (!reuse) begin
        a = wb + AW'(k);
        exp_q.push_back(a);
        for (int j = 0; j < L; j++) exp_w[k*L+j] = lane_val(a, j);
      end
    end
    for (int k = 0; k < WORDS; k++) begin
      a = db + AW'(k);
      exp_q.push_back(a);
      for (int j = 0; j < L; j++) exp_d[k*L+j] = lane_val(a, j);
    end
    @(negedge clk);
    rd_cnt = 0; n_load = 0; n_done = 0; rd_at_load = -1; run_at_done = -1; overlap_cnt = 0;
    start = 1'b1; w_base_addr = wb; d_base_addr = db; reuse_weights = reuse;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic check_arrays();
    for (int e = 0; e < ELEMS; e++) begin
      check($sformatf("weights_in[%0d]", e), $unsigned(weights_in[e]), exp_w[e]);
      check($sformatf("datas_arr[%0d]", e), $unsigned(datas_arr[e]), exp_d[e]);
    end
  endtask

  task automatic run_tile(input logic [AW-1:0] wb, input logic [AW-1:0] db, input bit reuse,
                          input bit hammer, input bit chk_lat);
    int cyc;
    prep_and_start(wb, db, reuse);
    start = hammer;
    cyc = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      if (hammer) begin
        start = 1'($urandom_range(0, 1));
        w_base_addr = AW'($urandom);
        d_base_addr = AW'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    check("busy_low_in_done", busy, 0);
    if (hammer) start = 1'b1;
    if (chk_lat) check("latency", cyc, (reuse ? 1 : 2) * WORDS * 2 + (reuse ? 0 : 1) + CC + 1);
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    repeat (4) @(negedge clk);
    check("done_count", n_done, 1);
    check("load_count", n_load, reuse ? 0 : 1);
    if (!reuse) check("reads_before_load", rd_at_load, WORDS);
    check("compute_run", run_at_done, CC);
    check("read_count", rd_cnt, reuse ? WORDS : 2 * WORDS);
    check("addr_q_drained", exp_q.size(), 0);
    check("one_outstanding", overlap_cnt, 0);
    check("idle_busy", busy, 0);
    check_arrays();
  endtask

  task automatic check_all_zero(input string tag);
    int nz;
    nz = 0;
    for (int e = 0; e < ELEMS; e++) if (weights_in[e] !== '0 || datas_arr[e] !== '0) nz++;
    check({tag, "_arrays"}, nz, 0);
    check({tag, "_ctrl"}, {busy, done, load_en, compute, buf_rd_en}, 0);
    check({tag, "_addr"}, buf_rd_addr, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic abort_run(input bit in_comp);
    int r0, cyc;
    bit reached;
    r0 = resp_cnt;
    prep_and_start(10'h000, 10'h040, 1'b0);
    start = 1'b0;
    reached = 1'b0;
    cyc = 0;
    while (!reached && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
      reached = in_comp ? (cur_run >= 10) : (resp_cnt >= r0 + WORDS + 5);
    end
    check(in_comp ? "abort_point_comp" : "abort_point_rdd", reached, 1);
    if (!in_comp) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check_all_zero(in_comp ? "abort_comp" : "abort_rdd");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("no_done_after_abort", n_done, 0);
    check("idle_after_abort", busy, 0);
  endtask

  // directed sequence
  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    run_tile(10'h000, 10'h040, 1'b0, 1'b0, 1'b1);

    spur_on = 1'b1;
    run_tile(10'h000, 10'h040, 1'b0, 1'b0, 1'b0);
    spur_on = 1'b0;
    repeat (8) @(negedge clk);

    run_tile(10'h000, 10'h040, 1'b0, 1'b1, 1'b1);

    abort_run(1'b0);
    abort_run(1'b1);
    run_tile(10'h000, 10'h040, 1'b0, 1'b0, 1'b1);

    salt = 4'h6;
    run_tile(10'h3FE, 10'h100, 1'b0, 1'b0, 1'b1);

`ifdef PE_LOADER_WEIGHT_REUSE_EN
    salt = 4'h0;
    run_tile(10'h200, 10'h300, 1'b0, 1'b0, 1'b1);
    salt = 4'h9;
    run_tile(10'h000, 10'h310, 1'b1, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
